pc_ir_unit: RTL and testbench

PC_IR_UNIT -- requirements
Module: pc_ir_unit

---
 rtl/pc_ir_unit_pkg.sv | 19 +
 rtl/pc_ir_unit_if.sv | 23 ++
 rtl/pc_ir_unit_npc_mux.sv | 19 +
 rtl/pc_ir_unit.sv | 43 ++++
 tb/tb_pc_ir_unit.sv | 141 ++++++++++++++
 5 files changed

// File: rtl/pc_ir_unit_pkg.sv
// pc_ir_unit_pkg: shared control definitions for the PC/IR datapath slice
package pc_ir_unit_pkg;
    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam logic [31:0] NOP = 32'h0000_0000;
    typedef enum logic [1:0] {
        PCSRC_SEQ = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP = 2'b10,
        PCSRC_RSVD = 2'b11
    } pcsrc_e;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
    } aluop_e;
    typedef enum logic [1:0] {EXT_ZERO, EXT_SIGN, EXT_LUI} extop_e;
    function automatic logic [31:0] jump_target(input logic [3:0] pc_hi, input logic [25:0] idx);
        return {pc_hi, idx, 2'b00};
    endfunction
endpackage

// File: rtl/pc_ir_unit_if.sv
// pc_ir_if: ctrl/datapath signals feeding the PC/IR unit and the state it exposes
interface pc_ir_if;
    logic        PCWrite;
    logic        PCWriteCond;
    logic [1:0]  PCSrc;
    logic        IRWrite;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic [31:0] mem_rdata;
    logic [31:0] currentPC;
    logic [31:0] instr;
    logic [31:0] alu_out;
    logic        pc_err;
    logic [31:0] instr_count;
    modport master (
        output PCWrite, PCWriteCond, PCSrc, IRWrite, alu_result, alu_zero, mem_rdata,
        input  currentPC, instr, alu_out, pc_err, instr_count
    );
    modport slave (
        input  PCWrite, PCWriteCond, PCSrc, IRWrite, alu_result, alu_zero, mem_rdata,
        output currentPC, instr, alu_out, pc_err, instr_count
    );
endinterface

// File: rtl/pc_ir_unit_npc_mux.sv
// npc_mux: next-PC selection plus legality (reserved select or misaligned target)
import pc_ir_unit_pkg::*;
module npc_mux (
    input  logic [1:0]  pc_src,
    input  logic [31:0] alu_result,
    input  logic [31:0] alu_out,
    input  logic [31:0] current_pc,
    input  logic [25:0] jump_index,
    output logic [31:0] next_pc,
    output logic        npc_illegal
);
    always_comb begin
        next_pc = pc_src == PCSRC_SEQ    ? alu_result :
                  pc_src == PCSRC_ALUOUT ? alu_out :
                  pc_src == PCSRC_JUMP   ? jump_target(current_pc[31:28], jump_index) :
                                           current_pc;
        npc_illegal = pc_src == PCSRC_RSVD || next_pc[1:0] != 2'b00;
    end
endmodule

// File: rtl/pc_ir_unit.sv
// pc_ir_unit: PC, IR and ALUOut registers of a multicycle CPU with illegal-update detection
import pc_ir_unit_pkg::*;
module pc_ir_unit (
    input  logic   clk,
    input  logic   rst_n,
    pc_ir_if.slave bus
);
    logic [31:0] pc_q, instr_q, alu_out_q, cnt_q, next_pc;
    logic        err_q, npc_illegal, pc_we;
    assign pc_we = bus.PCWrite | (bus.PCWriteCond & bus.alu_zero);
    npc_mux u_npc (
        .pc_src      (bus.PCSrc),
        .alu_result  (bus.alu_result),
        .alu_out     (alu_out_q),
        .current_pc  (pc_q),
        .jump_index  (instr_q[25:0]),
        .next_pc     (next_pc),
        .npc_illegal (npc_illegal)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= PC_RESET;
            instr_q   <= NOP;
            alu_out_q <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            // an illegal target leaves the PC alone and latches the error
            if (pc_we && !npc_illegal) pc_q <= next_pc;
            if (pc_we && npc_illegal) err_q <= 1'b1;
            if (bus.IRWrite) begin
                instr_q <= bus.mem_rdata;
                cnt_q   <= cnt_q + 32'd1;
            end
            alu_out_q <= bus.alu_result;
        end
    end
    assign bus.currentPC   = pc_q;
    assign bus.instr       = instr_q;
    assign bus.alu_out     = alu_out_q;
    assign bus.pc_err      = err_q;
    assign bus.instr_count = cnt_q;
endmodule

// File: tb/tb_pc_ir_unit.sv
// tb_pc_ir_unit: directed scenarios plus randomized traffic against a behavioural model
module tb_pc_ir_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    pc_ir_if bus();
    pc_ir_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;
    logic preload = 1'b0;
    logic [31:0] m_pc, m_instr, m_alu_out, m_cnt;
    logic m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // reference: pick the target by select code, legal only if word-aligned and not reserved
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = 32'h3000; m_instr = 0; m_alu_out = 0; m_err = 0; m_cnt = 0;
        end else begin
            logic [31:0] tgt;
            logic wr, bad;
            if (preload) m_cnt = 32'hFFFF_FFFF;
            wr = bus.PCWrite || (bus.PCWriteCond && bus.alu_zero);
            case (bus.PCSrc)
                2'd0: tgt = bus.alu_result;
                2'd1: tgt = m_alu_out;
                2'd2: tgt = (m_pc & 32'hF000_0000) + ((m_instr & 32'h03FF_FFFF) * 4);
                default: tgt = m_pc;
            endcase
            bad = bus.PCSrc == 2'd3 || (tgt % 4) != 0;
            if (wr && !bad) m_pc = tgt;
            if (wr && bad) m_err = 1;
            if (bus.IRWrite) begin
                m_instr = bus.mem_rdata;
                m_cnt = m_cnt + 1;
            end
            m_alu_out = bus.alu_result;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("pc", bus.currentPC, m_pc);
            check("instr", bus.instr, m_instr);
            check("alu_out", bus.alu_out, m_alu_out);
            check("pc_err", {31'd0, bus.pc_err}, {31'd0, m_err});
            check("instr_count", bus.instr_count, m_cnt);
        end
    end

    task automatic drive(input logic pw, input logic pwc, input logic [1:0] src, input logic irw,
                         input logic [31:0] ar, input logic az, input logic [31:0] md);
        bus.PCWrite = pw; bus.PCWriteCond = pwc; bus.PCSrc = src; bus.IRWrite = irw;
        bus.alu_result = ar; bus.alu_zero = az; bus.mem_rdata = md;
    endtask

    task automatic step(input logic pw, input logic pwc, input logic [1:0] src, input logic irw,
                        input logic [31:0] ar, input logic az, input logic [31:0] md);
        drive(pw, pwc, src, irw, ar, az, md);
        @(negedge clk);
    endtask

    initial begin
        drive(0, 0, 2'd0, 0, 32'h0, 0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        check("rst_pc", bus.currentPC, 32'h3000);
        check("rst_instr", bus.instr, 32'h0);
        check("rst_cnt", bus.instr_count, 32'h0);
        check("rst_err", {31'd0, bus.pc_err}, 32'h0);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        step(1, 0, 2'd0, 1, 32'h3004, 0, 32'h2008_0005);
        check("fetch_pc", bus.currentPC, 32'h3004);
        check("fetch_instr", bus.instr, 32'h2008_0005);
        check("fetch_cnt", bus.instr_count, 32'd1);
        step(0, 0, 2'd0, 0, 32'h3020, 0, 32'h0);
        step(0, 1, 2'd1, 0, 32'h0, 1, 32'h0);
        check("beq_taken", bus.currentPC, 32'h3020);
        step(0, 0, 2'd0, 0, 32'h3080, 0, 32'h0);
        step(0, 1, 2'd1, 0, 32'h0, 0, 32'h0);
        check("beq_not_taken", bus.currentPC, 32'h3020);
        step(1, 0, 2'd0, 1, 32'h3008, 0, 32'h0800_0C10);
        check("j_setup_pc", bus.currentPC, 32'h3008);
        step(1, 0, 2'd2, 0, 32'h0, 0, 32'h0);
        check("jump_pc", bus.currentPC, 32'h3040);
        step(0, 1, 2'd3, 0, 32'h3001, 0, 32'h0);
        check("no_we_err", {31'd0, bus.pc_err}, 32'h0);
        check("no_we_pc", bus.currentPC, 32'h3040);
        step(1, 0, 2'd0, 0, 32'h3006, 0, 32'h0);
        check("misalign_pc", bus.currentPC, 32'h3040);
        check("misalign_err", {31'd0, bus.pc_err}, 32'h1);
        step(1, 0, 2'd0, 0, 32'h300C, 0, 32'h0);
        check("recover_pc", bus.currentPC, 32'h300C);
        check("sticky_err", {31'd0, bus.pc_err}, 32'h1);
        drive(0, 0, 2'd0, 1, 32'h0, 0, 32'h1234_5678);
        #2;
        force dut.cnt_q = 32'hFFFF_FFFF;
        preload = 1'b1;
        #1;
        release dut.cnt_q;
        @(negedge clk);
        preload = 1'b0;
        check("cnt_wrap", bus.instr_count, 32'h0);
        drive(0, 1, 2'd1, 0, 32'h0, 1, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_pc", bus.currentPC, 32'h3000);
        check("async_err", {31'd0, bus.pc_err}, 32'h0);
        check("async_instr", bus.instr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 1, 2'd0, 0, 32'h3010, 0, 32'h0);
        check("post_rst_pc", bus.currentPC, 32'h3010);
        for (int i = 0; i < 600; i++) begin
            logic [31:0] ar;
            ar = ($urandom_range(0, 7) == 0) ? $urandom : 32'h3000 + ($urandom_range(0, 255) << 2);
            if ($urandom_range(0, 9) == 0) ar = ar | 32'($urandom_range(1, 3));
            drive($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
                  $urandom_range(0, 1) == 1, ar, $urandom_range(0, 1) == 1, $urandom);
            if ($urandom_range(0, 59) == 0) begin
                #2 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            @(negedge clk);
        end
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
